fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, and the sequential consumer of the PC+4 increment: it owns the program-counter register, drives the instruction-memory request/acknowledge handshake, and loads the IF/ID pipeline register. It handles decode stalls with a one-entry skid buffer, and it handles branch/jump redirects from EX, including discarding a fetch that is already in flight.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/fetch_unit_inc.sv | 11 +
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the 5-stage core.
// FETCH_MISALIGN_TRAP_EN adds the MISALIGN_IDLE fetch state.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        SKID,
        DISCARD
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        MISALIGN_IDLE
`endif
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_inc.sv
// PC+4 incrementer; wraps modulo 2^XLEN.
module fetch_unit_inc
    import pipeline_pkg::*;
(
    input  logic [XLEN-1:0] a,
    output logic [XLEN-1:0] y
);

    assign y = a + XLEN'(4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, skid buffer, IF/ID register.
// FETCH_MISALIGN_TRAP_EN enables the fetch_misalign trap on redirects.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_d,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign
`endif
);

    fetch_state_t    state, state_nx;
    logic [XLEN-1:0] pc, pc_nx;
    logic [XLEN-1:0] disc_addr, disc_addr_nx;
    logic [XLEN-1:0] pc_inc, fetch_inc, redir_tgt;
    if_id_t          if_id, if_id_nx;
    if_id_t          skid, skid_nx;
    logic            slot_free;

    localparam if_id_t IF_ID_RST = '{
        valid:    1'b0,
        pc:       '0,
        pc_plus4: '0,
        instr:    NOP_INSTR
    };

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_tgt = redirect_pc;
`else
    assign redir_tgt = redirect_pc & ~XLEN'(3);
`endif

    fetch_unit_inc u_pc_inc (.a(pc), .y(pc_inc));
    fetch_unit_inc u_fetch_inc (.a(imem_addr), .y(fetch_inc));

    assign imem_req  = (state == REQ) || (state == DISCARD);
    // DISCARD keeps the abandoned address on the bus until it is acked
    assign imem_addr = (state == DISCARD) ? disc_addr : pc;
    assign slot_free = !if_id.valid || !stall_d;

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        disc_addr_nx = disc_addr;
        skid_nx      = skid;
        if_id_nx     = if_id;
        if (if_id.valid && !stall_d) begin
            if_id_nx.valid = 1'b0;
            if_id_nx.instr = NOP_INSTR;
        end
        if (redirect_valid) begin
            if_id_nx.valid = 1'b0;
            if_id_nx.instr = NOP_INSTR;
            skid_nx.valid  = 1'b0;
            pc_nx          = redir_tgt;
            if (state == REQ && !imem_ack) begin
                state_nx     = DISCARD;
                disc_addr_nx = pc;
            end else if (state == DISCARD && !imem_ack) begin
                state_nx = DISCARD;
`ifdef FETCH_MISALIGN_TRAP_EN
            end else if (misalign) begin
                state_nx = MISALIGN_IDLE;
`endif
            end else begin
                state_nx = REQ;
            end
        end else begin
            unique case (state)
                BOOT: state_nx = REQ;
                REQ: begin
                    if (imem_ack) begin
                        pc_nx = pc_inc;
                        if (slot_free) begin
                            if_id_nx = '{1'b1, pc, fetch_inc, imem_rdata};
                        end else begin
                            skid_nx  = '{1'b1, pc, fetch_inc, imem_rdata};
                            state_nx = SKID;
                        end
                    end
                end
                SKID: begin
                    if (!stall_d) begin
                        if_id_nx      = skid;
                        skid_nx.valid = 1'b0;
                        state_nx      = REQ;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        state_nx = (pc[1:0] != 2'b00) ? MISALIGN_IDLE : REQ;
`else
                        state_nx = REQ;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                MISALIGN_IDLE: state_nx = MISALIGN_IDLE;
`endif
                default: state_nx = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            disc_addr <= RESET_PC;
            if_id     <= IF_ID_RST;
            skid      <= IF_ID_RST;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            disc_addr <= disc_addr_nx;
            if_id     <= if_id_nx;
            skid      <= skid_nx;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) fetch_misalign <= 1'b0;
        else     fetch_misalign <= misalign;
    end
`endif

    assign if_id_valid    = if_id.valid;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_instr    = if_id.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against an instruction-stream reference model.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Memory answers within the current cycle when ack_en and a request is up
    task automatic drive(input logic ack_en, input logic st,
                         input logic rv, input logic [31:0] tgt);
        stall_d        = st;
        redirect_valid = rv;
        redirect_pc    = tgt;
        imem_ack       = ack_en && imem_req;
        imem_rdata     = imem_ack ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        n_checks++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4,
             if_id_instr} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP})
            $display("FAIL reset_state got req=%b addr=%h v=%b pc=%h p4=%h ins=%h",
                     imem_req, imem_addr, if_id_valid, if_id_pc,
                     if_id_pc_plus4, if_id_instr);
        else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++;
        if (fetch_misalign !== 1'b0)
            $display("FAIL reset_misalign got=%b exp=0", fetch_misalign);
        else n_pass++;
`endif
        rst = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0)
            $display("FAIL boot_req got=%b exp=0", imem_req);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
    endtask

    task automatic test_free_run;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ep;
            ep = 32'(i - 1) * 4;
            n_checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(i) * 4})
                $display("FAIL run_req[%0d] got req=%b addr=%h exp addr=%h",
                         i, imem_req, imem_addr, 32'(i) * 4);
            else n_pass++;
            n_checks++;
            if (i == 0) begin
                if ({if_id_valid, if_id_instr} !== {1'b0, NOP})
                    $display("FAIL run_ifid[0] got v=%b ins=%h exp v=0",
                             if_id_valid, if_id_instr);
                else n_pass++;
            end else if ({if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr}
                         !== {1'b1, ep, ep + 32'd4, ep ^ KEY}) begin
                $display("FAIL run_ifid[%0d] got v=%b pc=%h p4=%h ins=%h exp pc=%h",
                         i, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, ep);
            end else n_pass++;
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tick;
        end
    endtask

    task automatic test_stall;
        n_checks++;
        if ({if_id_valid, if_id_pc, imem_addr} !== {1'b1, 32'h8, 32'hC})
            $display("FAIL stall_pre got v=%b pc=%h addr=%h exp pc=8 addr=c",
                     if_id_valid, if_id_pc, imem_addr);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({imem_req, if_id_valid, if_id_pc} !== {1'b0, 1'b1, 32'h8})
                $display("FAIL stall_hold[%0d] got req=%b v=%b pc=%h exp req=0 pc=8",
                         i, imem_req, if_id_valid, if_id_pc);
            else n_pass++;
            drive(1'b1, (i < 2), 1'b0, 32'h0);
            tick;
        end
        n_checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr}
            !== {1'b1, 32'hC, 32'hC ^ KEY, 1'b1, 32'h10})
            $display("FAIL stall_release got v=%b pc=%h ins=%h req=%b addr=%h",
                     if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_wait_states;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h10})
                $display("FAIL wait_addr[%0d] got req=%b addr=%h exp addr=10",
                         i, imem_req, imem_addr);
            else n_pass++;
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            tick;
            n_checks++;
            if (if_id_valid !== 1'b0)
                $display("FAIL wait_ifid[%0d] got v=%b exp 0", i, if_id_valid);
            else n_pass++;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        n_checks++;
        if ({if_id_valid, if_id_pc, imem_addr} !== {1'b1, 32'h10, 32'h14})
            $display("FAIL wait_load got v=%b pc=%h addr=%h exp pc=10 addr=14",
                     if_id_valid, if_id_pc, imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_inflight;
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        tick;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h14, 1'b0})
                $display("FAIL disc_hold[%0d] got req=%b addr=%h v=%b exp addr=14 v=0",
                         i, imem_req, imem_addr, if_id_valid);
            else n_pass++;
            drive((i == 1), 1'b0, 1'b0, 32'h0);
            tick;
        end
        n_checks++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL disc_target got req=%b addr=%h v=%b exp addr=100 v=0",
                     imem_req, imem_addr, if_id_valid);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        n_checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr}
            !== {1'b1, 32'h100, 32'h100 ^ KEY, 32'h104})
            $display("FAIL disc_first got v=%b pc=%h ins=%h addr=%h exp pc=100",
                     if_id_valid, if_id_pc, if_id_instr, imem_addr);
        else n_pass++;
    endtask

    task automatic test_wrap;
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick;
        n_checks++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0})
            $display("FAIL wrap_req got req=%b addr=%h v=%b exp addr=fffffffc v=0",
                     imem_req, imem_addr, if_id_valid);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        n_checks++;
        if ({if_id_valid, if_id_pc, if_id_pc_plus4, imem_addr}
            !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0})
            $display("FAIL wrap_ifid got v=%b pc=%h p4=%h addr=%h exp p4=0 addr=0",
                     if_id_valid, if_id_pc, if_id_pc_plus4, imem_addr);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        n_checks++;
        if ({if_id_valid, if_id_pc, if_id_pc_plus4} !== {1'b1, 32'h0, 32'h4})
            $display("FAIL wrap_next got v=%b pc=%h p4=%h exp pc=0 p4=4",
                     if_id_valid, if_id_pc, if_id_pc_plus4);
        else n_pass++;
    endtask

    task automatic test_misalign;
        drive(1'b1, 1'b0, 1'b1, 32'h102);
        tick;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++;
        if ({fetch_misalign, imem_req, if_id_valid} !== 3'b100)
            $display("FAIL mis_pulse got mis=%b req=%b v=%b exp 1/0/0",
                     fetch_misalign, imem_req, if_id_valid);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        n_checks++;
        if ({fetch_misalign, imem_req, if_id_valid} !== 3'b000)
            $display("FAIL mis_idle got mis=%b req=%b v=%b exp 0/0/0",
                     fetch_misalign, imem_req, if_id_valid);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b1, 32'h200);
        tick;
        n_checks++;
        if ({imem_req, imem_addr, fetch_misalign} !== {1'b1, 32'h200, 1'b0})
            $display("FAIL mis_resume got req=%b addr=%h mis=%b exp addr=200",
                     imem_req, imem_addr, fetch_misalign);
        else n_pass++;
`else
        n_checks++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL mask_low got req=%b addr=%h v=%b exp addr=100",
                     imem_req, imem_addr, if_id_valid);
        else n_pass++;
`endif
    endtask

    // Model: decode must see one unbroken sequential stream per redirect target
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_hold;
        logic        flushed;
        int          wait_cnt;
        int          consumed;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        rst = 1'b0;
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        prev_addr = '0;
        flushed   = 1'b0;
        wait_cnt  = 0;
        consumed  = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        st, rv;
            logic [31:0] tgt;
            if (prev_hold) begin
                n_checks++;
                if ({imem_req, imem_addr} !== {1'b1, prev_addr})
                    $display("FAIL rnd_req_hold[%0d] got req=%b addr=%h exp addr=%h",
                             c, imem_req, imem_addr, prev_addr);
                else n_pass++;
            end
            if (flushed) begin
                n_checks++;
                if ({if_id_valid, if_id_instr} !== {1'b0, NOP})
                    $display("FAIL rnd_flush[%0d] got v=%b ins=%h exp v=0",
                             c, if_id_valid, if_id_instr);
                else n_pass++;
            end
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 4095));
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`else
            tgt[1:0] = 2'($urandom_range(0, 3));
`endif
            drive((wait_cnt == 0), st, rv, tgt);
            if (if_id_valid && !st) begin
                n_checks++;
                if ({if_id_pc, if_id_pc_plus4, if_id_instr}
                    !== {exp_pc, exp_pc + 32'd4, exp_pc ^ KEY})
                    $display("FAIL rnd_stream[%0d] got pc=%h p4=%h ins=%h exp pc=%h",
                             c, if_id_pc, if_id_pc_plus4, if_id_instr, exp_pc);
                else n_pass++;
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rv) exp_pc = {tgt[31:2], 2'b00};
            flushed   = rv;
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (imem_ack) wait_cnt = $urandom_range(0, 2);
            else if (imem_req && wait_cnt > 0) wait_cnt--;
            tick;
        end
        n_checks++;
        if (consumed < 300)
            $display("FAIL rnd_progress got=%0d exp>=300", consumed);
        else n_pass++;
    endtask

    initial begin
        #2;
        test_reset;
        test_free_run;
        test_stall;
        test_wait_states;
        test_redirect_inflight;
        test_wrap;
        test_misalign;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
